// File: rtl/frogger_game_fsm_if.sv
// Control bundle between the Frogger game sequencer and its datapath.
// master = sequencer side, slave = collision checker / movers / display.
interface frogger_game_fsm_if;
  logic       i_Start;
  logic       i_Collision;
  logic       i_Frog_At_Goal;
  logic [2:0] o_State;
  logic       o_Move_En;
  logic       o_Frog_Reset;
  logic       o_Car_Tick;
  logic [1:0] o_Lives;
  logic [6:0] o_Score;
  logic [2:0] o_Level;
  logic       o_Blank;

  modport master (
    input  i_Start, i_Collision, i_Frog_At_Goal,
    output o_State, o_Move_En, o_Frog_Reset,
    output o_Car_Tick, o_Lives, o_Score,
    output o_Level, o_Blank
  );

  modport slave (
    output i_Start, i_Collision, i_Frog_At_Goal,
    input  o_State, o_Move_En, o_Frog_Reset,
    input  o_Car_Tick, o_Lives, o_Score,
    input  o_Level, o_Blank
  );
endinterface

// File: rtl/frogger_game_fsm.sv
// Frogger game sequencer: state, lives, score, level, level-scaled car tick.
// Define FROGGER_DEATH_BLINK_EN to build the death blink on o_Blank.
module frogger_game_fsm #(
  parameter int unsigned LIVES            = 3,
  parameter int unsigned MAX_LEVEL        = 7,
  parameter int unsigned BASE_TICK_CYCLES = 2_500_000,
  parameter int unsigned PAUSE_CYCLES     = 25_000_000,
  parameter int unsigned GUARD_CYCLES     = 4,
  parameter int unsigned BLINK_CYCLES     = 3_125_000
) (
  input logic                i_Clk,
  input logic                i_Rst_L,
  frogger_game_fsm_if.master bus
);

  localparam int unsigned TW = $clog2(BASE_TICK_CYCLES + 1);
  localparam int unsigned PW = $clog2(PAUSE_CYCLES + 1);
  localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);

  localparam logic [GW-1:0] GUARD_LD = GW'(GUARD_CYCLES);
  localparam logic [PW-1:0] PAUSE_LD = PW'(PAUSE_CYCLES - 1);
  localparam logic [1:0]    LIVES_LD = 2'(LIVES);
  localparam logic [2:0]    LVL_TOP  = 3'(MAX_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_DEATH = 3'd2,
    S_LVL   = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          start_q;
  logic [GW-1:0] guard_q, guard_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [PW-1:0] pause_q, pause_d;
  logic [1:0]    lives_q, lives_d;
  logic [6:0]    score_q, score_d;
  logic [2:0]    level_q, level_d;
  logic          move_q, move_d;
  logic          frst_q, frst_d;
  logic          tick_q, tick_d;
  logic          blank_q, blank_d;

  logic start_edge, armed, hit, goal;
  logic new_game, enter_play;
  logic pausing_q, pausing_d;

  function automatic logic [TW-1:0] reload_of(
    input logic [2:0] lvl
  );
    logic [31:0] p;
    p = 32'(BASE_TICK_CYCLES) >> lvl;
    if (p == 32'd0) p = 32'd1;
    return TW'(p - 32'd1);
  endfunction

  assign start_edge = bus.i_Start & ~start_q;
  assign armed      = (guard_q == '0);
  assign hit  = (state_q == S_PLAY) & armed
              & bus.i_Collision;
  assign goal = (state_q == S_PLAY) & armed
              & ~bus.i_Collision & bus.i_Frog_At_Goal;

  assign new_game = start_edge
                  & ((state_q == S_IDLE) | (state_q == S_OVER));
  assign enter_play = (state_d == S_PLAY)
                    & (state_q != S_PLAY);
  assign pausing_q = (state_q == S_DEATH) | (state_q == S_LVL);
  assign pausing_d = (state_d == S_DEATH) | (state_d == S_LVL);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == S_IDLE) || (state_q == S_OVER): begin
        if (start_edge) state_d = S_PLAY;
      end
      (state_q == S_PLAY): begin
        if (hit)       state_d = S_DEATH;
        else if (goal) state_d = S_LVL;
      end
      (state_q == S_DEATH): begin
        if (pause_q == '0)
          state_d = (lives_q == 2'd0) ? S_OVER : S_PLAY;
      end
      (state_q == S_LVL): begin
        if (pause_q == '0) state_d = S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    guard_d = guard_q;
    tcnt_d  = tcnt_q;
    pause_d = pause_q;
    lives_d = lives_q;
    score_d = score_q;
    level_d = level_q;

    if (new_game) begin
      lives_d = LIVES_LD;
      score_d = 7'd0;
      level_d = 3'd0;
    end
    if (hit) lives_d = lives_q - 2'd1;
    if (goal) begin
      if (score_q != 7'd99)  score_d = score_q + 7'd1;
      if (level_q != LVL_TOP) level_d = level_q + 3'd1;
    end

    if (enter_play)
      guard_d = GUARD_LD;
    else if (state_q == S_PLAY && guard_q != '0)
      guard_d = guard_q - GW'(1);

    // reload picks up the new level at the next PLAY entry
    if (enter_play)
      tcnt_d = reload_of(level_d);
    else if (state_q == S_PLAY)
      tcnt_d = (tcnt_q == '0) ? reload_of(level_d)
                              : tcnt_q - TW'(1);

    if (pausing_d && !pausing_q)
      pause_d = PAUSE_LD;
    else if (pausing_q && pause_q != '0)
      pause_d = pause_q - PW'(1);

    move_d = (state_d == S_PLAY);
    frst_d = enter_play;
    tick_d = (state_d == S_PLAY) && (tcnt_d == '0);
  end

`ifdef FROGGER_DEATH_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [BW-1:0] BLINK_LD = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] blink_q, blink_d;

  always_comb begin
    blink_d = blink_q;
    blank_d = 1'b0;
    if (state_d == S_DEATH) begin
      if (state_q != S_DEATH) begin
        blank_d = 1'b1;
        blink_d = BLINK_LD;
      end else if (blink_q == '0) begin
        blank_d = ~blank_q;
        blink_d = BLINK_LD;
      end else begin
        blank_d = blank_q;
        blink_d = blink_q - BW'(1);
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) blink_q <= '0;
    else          blink_q <= blink_d;
  end
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = ^BLINK_CYCLES;
  assign blank_d = 1'b0;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      start_q <= 1'b0;
      guard_q <= '0;
      tcnt_q  <= '0;
      pause_q <= '0;
      lives_q <= 2'd0;
      score_q <= 7'd0;
      level_q <= 3'd0;
      move_q  <= 1'b0;
      frst_q  <= 1'b0;
      tick_q  <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      start_q <= bus.i_Start;
      guard_q <= guard_d;
      tcnt_q  <= tcnt_d;
      pause_q <= pause_d;
      lives_q <= lives_d;
      score_q <= score_d;
      level_q <= level_d;
      move_q  <= move_d;
      frst_q  <= frst_d;
      tick_q  <= tick_d;
      blank_q <= blank_d;
    end
  end

  assign bus.o_State      = state_q;
  assign bus.o_Move_En    = move_q;
  assign bus.o_Frog_Reset = frst_q;
  assign bus.o_Car_Tick   = tick_q;
  assign bus.o_Lives      = lives_q;
  assign bus.o_Score      = score_q;
  assign bus.o_Level      = level_q;
  assign bus.o_Blank      = blank_q;

endmodule
